// File: rtl/prog_clk_divider.sv
`default_nettype none
// ============================================================================
// Module   : prog_clk_divider
// Brief    : NCH independent programmable clock dividers sharing one custom
//            divisor register. Optional tick pulses with PROG_CLK_DIVIDER_TICK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module prog_clk_divider #(
    parameter int          NCH   = 2,
    parameter int          CNT_W = 32,
    parameter int unsigned DIV0  = 12_500_000,
    parameter int unsigned DIV1  = 8_333_333,
    parameter int unsigned DIV2  = 6_250_000,
    parameter int unsigned DIV3  = 5_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     en,
    input  logic [NCH-1:0]     sync,
    input  logic [2*NCH-1:0]   mode,
    input  logic               load,
    input  logic [CNT_W-1:0]   load_data,
    output logic [NCH-1:0]     out_clk,
    output logic [NCH-1:0]     tick,
    output logic [2*NCH-1:0]   act_mode
);

    localparam logic [CNT_W-1:0] c_div0 = CNT_W'(DIV0);
    localparam logic [CNT_W-1:0] c_div1 = CNT_W'(DIV1);
    localparam logic [CNT_W-1:0] c_div2 = CNT_W'(DIV2);
    localparam logic [CNT_W-1:0] c_div3 = CNT_W'(DIV3);

    logic [CNT_W-1:0] r_cdiv;
    logic [CNT_W-1:0] r_cnt  [NCH];
    logic [CNT_W-1:0] r_adiv [NCH];
    logic [1:0]       r_act  [NCH];
    logic [NCH-1:0]   r_out;

    logic [CNT_W-1:0] w_sel_div [NCH];
    logic [NCH-1:0]   w_wrap;

    // A zero divisor is treated as one, so it wraps on every enabled cycle.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            case (mode[2*i +: 2])
                2'd0:    w_sel_div[i] = c_div0;
                2'd1:    w_sel_div[i] = c_div1;
                2'd2:    w_sel_div[i] = c_div2;
                default: w_sel_div[i] = r_cdiv;
            endcase
            w_wrap[i] = (r_adiv[i] == '0) || (r_cnt[i] >= (r_adiv[i] - 1'b1));
        end
    end

    // Channels sample r_cdiv before this write, so a same-cycle toggle sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cdiv <= c_div3;
        end else if (load) begin
            r_cdiv <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i]  <= '0;
                r_adiv[i] <= c_div0;
                r_act[i]  <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync[i]) begin
                    r_cnt[i]  <= '0;
                    r_out[i]  <= 1'b0;
                    r_adiv[i] <= w_sel_div[i];
                    r_act[i]  <= mode[2*i +: 2];
                end else if (en[i]) begin
                    if (w_wrap[i]) begin
                        r_cnt[i]  <= '0;
                        r_out[i]  <= ~r_out[i];
                        r_adiv[i] <= w_sel_div[i];
                        r_act[i]  <= mode[2*i +: 2];
                    end else begin
                        r_cnt[i]  <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign out_clk = r_out;

    always_comb begin
        act_mode = '0;
        for (int i = 0; i < NCH; i++) begin
            act_mode[2*i +: 2] = r_act[i];
        end
    end

`ifdef PROG_CLK_DIVIDER_TICK_EN
    logic [NCH-1:0] r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= '0;
        end else begin
            r_tick <= en & ~sync & w_wrap & ~r_out;
        end
    end

    assign tick = r_tick;
`else
    assign tick = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_clk_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_clk_divider
// Brief    : Directed scoreboard bench for prog_clk_divider (NCH=2, CNT_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_clk_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] en;
    logic [1:0] sync;
    logic [3:0] mode;
    logic       load;
    logic [7:0] load_data;
    logic [1:0] out_clk;
    logic [1:0] tick;
    logic [3:0] act_mode;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [1:0] out;
        logic [3:0] act;
        logic [1:0] tk;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] e_out;
    logic [3:0] e_act;
    string      cur_tag;

    prog_clk_divider #(
        .NCH   (2),
        .CNT_W (8),
        .DIV0  (4),
        .DIV1  (3),
        .DIV2  (2),
        .DIV3  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .mode      (mode),
        .load      (load),
        .load_data (load_data),
        .out_clk   (out_clk),
        .tick      (tick),
        .act_mode  (act_mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] o, input logic [3:0] a,
                         input logic [1:0] t);
        logic [1:0] t_want;
`ifdef PROG_CLK_DIVIDER_TICK_EN
        t_want = t;
`else
        t_want = 2'b00;
`endif
        checks++;
        assert (out_clk === o) else begin
            errors++;
            $error("FAIL %s out_clk got %b want %b", tag, out_clk, o);
        end
        checks++;
        assert (act_mode === a) else begin
            errors++;
            $error("FAIL %s act_mode got %b want %b", tag, act_mode, a);
        end
        checks++;
        assert (tick === t_want) else begin
            errors++;
            $error("FAIL %s tick got %b want %b", tag, tick, t_want);
        end
    endtask

    task automatic push(input logic [1:0] tk);
        exp_t e;
        e.tag = cur_tag;
        e.out = e_out;
        e.act = e_act;
        e.tk  = tk;
        sb.push_back(e);
    endtask

    task automatic push_hold(input int n);
        for (int k = 0; k < n; k++) push(2'b00);
    endtask

    // Channel 0 toggles; a rising edge carries an expected tick.
    task automatic push_toggle(input logic [1:0] new_act);
        e_out[0]   = ~e_out[0];
        e_act[1:0] = new_act;
        push({1'b0, e_out[0]});
    endtask

    task automatic push_half(input int h, input logic [1:0] new_act);
        push_hold(h - 1);
        push_toggle(new_act);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check(e.tag, e.out, e.act, e.tk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 2'b00; sync = 2'b00; mode = 4'b1000;
        load = 1'b0; load_data = 8'd0;
        e_out = 2'b00; e_act = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 2'b00, 4'b0000, 2'b00);

        // Mode 0 from reset: half-period 4; channel 1 stays disabled and frozen.
        en  = 2'b01;
        rst = 1'b0;
        cur_tag = "m0_period";
        repeat (3) push_half(4, 2'd0);
        drain();

        // Mode change two cycles into a half-period: finishes at 4, then 3.
        cur_tag = "m0_to_m1";
        push_hold(2);
        drain();
        mode[1:0] = 2'd1;
        push_hold(1);
        push_toggle(2'd1);
        repeat (2) push_half(3, 2'd1);
        drain();

        // Load coincident with the boundary: old cdiv (5) first, then 7.
        cur_tag = "cdiv_load";
        mode[1:0] = 2'd3;
        push_hold(2);
        drain();
        load = 1'b1; load_data = 8'd7;
        push_toggle(2'd3);
        drain();
        load = 1'b0;
        push_half(5, 2'd3);
        repeat (2) push_half(7, 2'd3);
        drain();

        // Freeze mid-count for 10 cycles, then resume from the held count.
        cur_tag = "en_freeze";
        push_hold(3);
        drain();
        en = 2'b00;
        push_hold(10);
        drain();
        en = 2'b01;
        cur_tag = "en_resume";
        push_hold(3);
        push_toggle(2'd3);
        drain();

        // Sync on both channels: output cleared, new mode adopted at once.
        cur_tag = "sync";
        push_hold(2);
        drain();
        mode = 4'b1001;
        sync = 2'b11;
        e_out = 2'b00;
        e_act = 4'b1001;
        push(2'b00);
        drain();
        sync = 2'b00;
        cur_tag = "post_sync";
        repeat (2) push_half(3, 2'd1);
        drain();

        // Custom divisor of zero: toggles every cycle once adopted.
        cur_tag = "cdiv_zero";
        mode[1:0] = 2'd3;
        load = 1'b1; load_data = 8'd0;
        push_hold(1);
        drain();
        load = 1'b0;
        push_hold(1);
        push_toggle(2'd3);
        repeat (4) push_toggle(2'd3);
        drain();

        // Asynchronous reset between edges, then cdiv must read back as 5.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 2'b00, 4'b0000, 2'b00);
        e_out = 2'b00;
        e_act = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur_tag = "cdiv_after_rst";
        push_half(4, 2'd3);
        push_half(5, 2'd3);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
